// File: rtl/approx_mul8_seq.sv
// Sequenced 8x8 approximate multiplier: one approx_3 4x4 core is reused across four nibble steps.
// Build option: define APPROX_MUL8_SEQ_EXACT_LL_EN to compute the aL*bL step exactly.

module approx_3 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);
  // Columns 0..5 OR their partial-product bits; column 6 is split on x2y2 to recover some carry weight.
  assign z[0] = x[0] & y[0];
  assign z[1] = (x[0] & y[1]) | (x[1] & y[0]);
  assign z[2] = (x[0] & y[2]) | (x[1] & y[1]) | (x[2] & y[0]);
  assign z[3] = (x[0] & y[3]) | (x[1] & y[2]) | (x[2] & y[1]) | (x[3] & y[0]);
  assign z[4] = (x[1] & y[3]) | (x[2] & y[2]) | (x[3] & y[1]);
  assign z[5] = (x[2] & y[3]) | (x[3] & y[2]);
  assign z[6] = x[3] & y[3] & ~(x[2] & y[2]);
  assign z[7] = x[3] & y[3] & x[2] & y[2];
endmodule

module approx_mul8_seq #(
  parameter int unsigned ZERO_SKIP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [1:0]  idx;
  logic [2:0]  nxt;       // {no step left, next step index}
  logic [3:0]  core_x, core_y;
  logic [7:0]  core_z, prod;
  logic [15:0] addend;

  // A step is skippable only when skipping is enabled and its nibble pair holds a zero.
  function automatic logic [3:0] skip_mask(input logic [7:0] av, input logic [7:0] bv);
    logic [3:0] m;
    m[0] = (av[3:0] == 4'h0) || (bv[3:0] == 4'h0);
    m[1] = (av[3:0] == 4'h0) || (bv[7:4] == 4'h0);
    m[2] = (av[7:4] == 4'h0) || (bv[3:0] == 4'h0);
    m[3] = (av[7:4] == 4'h0) || (bv[7:4] == 4'h0);
    return (ZERO_SKIP != 0) ? m : 4'b0000;
  endfunction

  function automatic logic [2:0] find_step(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--)
      if (i >= int'(start) && !mask[i]) r = {1'b0, 2'(i)};
    return r;
  endfunction

  // In IDLE the live operands decide the first step, so an all-skip pair goes straight to DONE.
  always_comb begin
    if (state == IDLE) nxt = find_step(skip_mask(a, b), 3'd0);
    else               nxt = find_step(skip_mask(a_q, b_q), {1'b0, idx} + 3'd1);
  end

  assign core_x = idx[1] ? a_q[7:4] : a_q[3:0];
  assign core_y = idx[0] ? b_q[7:4] : b_q[3:0];

  approx_3 u_core (.x(core_x), .y(core_y), .z(core_z));

`ifdef APPROX_MUL8_SEQ_EXACT_LL_EN
  assign prod = (idx == 2'd0) ? ({4'h0, core_x} * {4'h0, core_y}) : core_z;
`else
  assign prod = core_z;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    addend = 16'h0000;
    case (idx)
      2'd0:    addend = {8'h00, prod};
      2'd1,
      2'd2:    addend = {4'h0, prod, 4'h0};
      default: addend = {prod, 8'h00};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = nxt[2] ? DONE : STEP;
      STEP:    if (nxt[2]) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
      acc <= 16'h0000;
      idx <= 2'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          acc <= 16'h0000;
          idx <= nxt[1:0];
        end
        STEP: begin
          acc <= acc + addend;   // worst case 0xD7C1, never wraps
          if (!nxt[2]) idx <= nxt[1:0];
        end
        DONE: if (out_ready) idx <= 2'd0;
        default: ;
      endcase
    end
  end

  assign p = acc;
endmodule

// File: tb/tb_approx_mul8_seq.sv
// Scoreboard bench for approx_mul8_seq: instance 0 with ZERO_SKIP=0, instance 1 with ZERO_SKIP=1.
module tb_approx_mul8_seq;
  logic clk = 1'b0;
  logic [1:0]       rst, in_valid, out_ready;
  logic [1:0]       in_ready, out_valid, busy;
  logic [1:0][7:0]  a, b;
  logic [1:0][15:0] p;

  int compared   = 0;
  int mismatched = 0;

  typedef struct { logic [15:0] p; int lat; } exp_t;
  exp_t sb[$];

`ifdef APPROX_MUL8_SEQ_EXACT_LL_EN
  localparam logic [15:0] P_0303 = 16'h0009;
  localparam logic [15:0] P_FFFF = 16'hD7C1;
`else
  localparam logic [15:0] P_0303 = 16'h0007;
  localparam logic [15:0] P_FFFF = 16'hD79F;
`endif

  always #5 clk = ~clk;

  approx_mul8_seq #(.ZERO_SKIP(0)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .p(p[0]), .busy(busy[0]));

  approx_mul8_seq #(.ZERO_SKIP(1)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .p(p[1]), .busy(busy[1]));

  function automatic logic [7:0] core_ref(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] z;
    z = 8'h00;
    for (int c = 0; c < 6; c++)
      for (int i = 0; i < 4; i++)
        if (c - i >= 0 && c - i < 4 && x[i] && y[c-i]) z[c] = 1'b1;
    z[6] = x[3] & y[3] & ~(x[2] & y[2]);
    z[7] = x[3] & y[3] & x[2] & y[2];
    return z;
  endfunction

  function automatic logic [15:0] mul_ref(input logic [7:0] av, input logic [7:0] bv);
    logic [15:0] ll;
`ifdef APPROX_MUL8_SEQ_EXACT_LL_EN
    ll = 16'(av[3:0]) * 16'(bv[3:0]);
`else
    ll = 16'(core_ref(av[3:0], bv[3:0]));
`endif
    return ll + (16'(core_ref(av[3:0], bv[7:4])) << 4) + (16'(core_ref(av[7:4], bv[3:0])) << 4)
              + (16'(core_ref(av[7:4], bv[7:4])) << 8);
  endfunction

  function automatic int lat_ref(input int k, input logic [7:0] av, input logic [7:0] bv);
    int n;
    if (k == 0) return 5;
    n = 0;
    if (av[3:0] != 4'h0 && bv[3:0] != 4'h0) n++;
    if (av[3:0] != 4'h0 && bv[7:4] != 4'h0) n++;
    if (av[7:4] != 4'h0 && bv[3:0] != 4'h0) n++;
    if (av[7:4] != 4'h0 && bv[7:4] != 4'h0) n++;
    return 1 + n;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] p_exp, input int lat_exp, input int hold);
    exp_t e;
    int   lat;
    compared++;
    if (in_ready[k] !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_ready dut%0d: in_ready=%b want 1", k, in_ready[k]);
    end
    a[k] = av; b[k] = bv; in_valid[k] = 1'b1; out_ready[k] = (hold == 0);
    sb.push_back('{p_exp, lat_exp});
    @(posedge clk); #1;
    in_valid[k] = 1'b0; a[k] = 8'($urandom); b[k] = 8'($urandom);
    compared++;
    if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL accept_state dut%0d: busy=%b in_ready=%b want 1/0", k, busy[k], in_ready[k]);
    end
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    compared++;
    if (out_valid[k] !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout dut%0d a=%h b=%h: no out_valid within %0d cycles", k, av, bv, lat);
      rst[k] = 1'b1; #1; rst[k] = 1'b0; out_ready[k] = 1'b0;
      return;
    end
    compared++;
    if (p[k] !== e.p) begin
      mismatched++;
      $display("FAIL product dut%0d a=%h b=%h: p=%h want %h", k, av, bv, p[k], e.p);
    end
    compared++;
    if (lat != e.lat) begin
      mismatched++;
      $display("FAIL latency dut%0d a=%h b=%h: %0d want %0d", k, av, bv, lat, e.lat);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      compared++;
      if (out_valid[k] !== 1'b1 || p[k] !== e.p || in_ready[k] !== 1'b0) begin
        mismatched++;
        $display("FAIL hold dut%0d cycle %0d: out_valid=%b p=%h in_ready=%b want 1/%h/0",
                 k, c, out_valid[k], p[k], in_ready[k], e.p);
      end
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL retire dut%0d: out_valid=%b in_ready=%b busy=%b want 0/1/0",
               k, out_valid[k], in_ready[k], busy[k]);
    end
    out_ready[k] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    compared++;
    if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || p[k] !== 16'h0000 || busy[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL %s dut%0d: in_ready=%b out_valid=%b p=%h busy=%b want 1/0/0000/0",
               tag, k, in_ready[k], out_valid[k], p[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_reset_outputs(k, "reset");
    rst = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_vectors();
    do_op(0, 8'h12, 8'h34, 16'h03A8, 5, 0);
    do_op(0, 8'h03, 8'h03, P_0303, 5, 0);
    do_op(0, 8'hFF, 8'hFF, P_FFFF, 5, 0);
    do_op(0, 8'h00, 8'h5A, 16'h0000, 5, 0);
  endtask

  task automatic test_zero_skip();
    do_op(1, 8'h01, 8'h01, 16'h0001, 2, 0);
    do_op(1, 8'h00, 8'hA7, 16'h0000, 1, 0);
    do_op(1, 8'h12, 8'h34, 16'h03A8, 5, 0);
    do_op(1, 8'hFF, 8'hFF, P_FFFF, 5, 0);
    do_op(1, 8'h10, 8'h01, mul_ref(8'h10, 8'h01), 2, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] av, bv;
    for (int n = 0; n < 40; n++) begin
      int k;
      k = n % 2;
      av = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      bv = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) == 0) av[3:0] = 4'h0;
      if ($urandom_range(0, 3) == 0) bv[7:4] = 4'h0;
      do_op(k, av, bv, mul_ref(av, bv), lat_ref(k, av, bv), 0);
    end
  endtask

  task automatic test_backpressure();
    do_op(0, 8'hC3, 8'h5E, mul_ref(8'hC3, 8'h5E), 5, 10);
    repeat (3) begin
      @(posedge clk); #1;
      compared++;
      if (out_valid[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL single_retire dut0: out_valid=%b want 0", out_valid[0]);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    a[0] = 8'hFF; b[0] = 8'hFF; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (busy[0] !== 1'b1 || p[0] === 16'h0000) begin
      mismatched++;
      $display("FAIL mid_step dut0: busy=%b p=%h want 1/nonzero", busy[0], p[0]);
    end
    rst[0] = 1'b1;
    #1;
    check_reset_outputs(0, "abort");
    @(posedge clk); #1;
    rst[0] = 1'b0;
    do_op(0, 8'hFF, 8'hFF, P_FFFF, 5, 0);
  endtask

  initial begin
    rst = 2'b11; in_valid = 2'b00; out_ready = 2'b00;
    a = '0; b = '0;
    test_reset();
    test_spec_vectors();
    test_zero_skip();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
